// File: rtl/simt_branch_ctrl_if.sv
// Bundle of branch-op handshake, pstack control and status signals for simt_branch_ctrl.
// The slave side is the controller; the master side is the requester, the pstack and status consumers.
interface simt_branch_ctrl_if #(
    parameter int N_CORES  = 4,
    parameter int PC_WIDTH = 8,
    parameter int DEPTH_W  = 4
);
    logic                op_valid;
    logic                op_ready;
    logic [1:0]          op_code;
    logic [N_CORES-1:0]  op_cond;
    logic [PC_WIDTH-1:0] op_target;

    logic [N_CORES-1:0]  ps_d;
    logic                ps_push;
    logic                ps_pop;
    logic                ps_comp;
    logic [N_CORES-1:0]  ps_q;
    logic                ps_all_false;

    logic [N_CORES-1:0]  active_mask;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic [DEPTH_W-1:0]  depth;
    logic                err_overflow;
    logic                err_underflow;

    modport slave (
        input  op_valid, op_code, op_cond, op_target, ps_q, ps_all_false,
        output op_ready, ps_d, ps_push, ps_pop, ps_comp,
               active_mask, redirect_valid, redirect_pc, depth,
               err_overflow, err_underflow
    );

    modport master (
        output op_valid, op_code, op_cond, op_target, ps_q, ps_all_false,
        input  op_ready, ps_d, ps_push, ps_pop, ps_comp,
               active_mask, redirect_valid, redirect_pc, depth,
               err_overflow, err_underflow
    );
endinterface

// File: rtl/simt_branch_ctrl.sv
// SIMT divergence controller: turns IF/ELSE/ENDIF ops into one-cycle pstack pulses,
// redirects the PC when the new active path is empty, and tracks nesting depth and errors.
module simt_branch_ctrl #(
    parameter int N_CORES     = 4,
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 8,
    parameter int DEPTH_W     = 4
) (
    input logic               clk,
    input logic               reset,
    simt_branch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_IF    = 2'b01;
    localparam logic [1:0] OP_ELSE  = 2'b10;
    localparam logic [1:0] OP_ENDIF = 2'b11;

    localparam logic [DEPTH_W-1:0] MAX_DEPTH = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] ONE       = DEPTH_W'(1);

    state_t              state_q, state_d;
    logic [1:0]          op_code_q, op_code_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                issued_q, issued_d;
    logic                err_ovf_q, err_ovf_d;
    logic                err_unf_q, err_unf_d;
    logic [PC_WIDTH-1:0] redir_pc_q, redir_pc_d;

    logic [N_CORES-1:0]  op_cond_q;
    logic [PC_WIDTH-1:0] op_target_q;
    logic                latch_en;

    logic                push_c, pop_c, comp_c, redir_c;
    logic [N_CORES-1:0]  ps_d_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_code_q  <= OP_NOP;
            depth_q    <= '0;
            issued_q   <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_unf_q  <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            op_code_q  <= op_code_d;
            depth_q    <= depth_d;
            issued_q   <= issued_d;
            err_ovf_q  <= err_ovf_d;
            err_unf_q  <= err_unf_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    // Operand payload is qualified by the FSM state, so it carries no reset.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            op_cond_q   <= bus.op_cond;
            op_target_q <= bus.op_target;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_code_d  = op_code_q;
        depth_d    = depth_q;
        issued_d   = issued_q;
        err_ovf_d  = err_ovf_q;
        err_unf_d  = err_unf_q;
        redir_pc_d = redir_pc_q;
        latch_en   = 1'b0;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        comp_c     = 1'b0;
        redir_c    = 1'b0;
        ps_d_c     = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.op_valid && (bus.op_code != OP_NOP)) begin
                    latch_en  = 1'b1;
                    op_code_d = bus.op_code;
                    state_d   = S_ISSUE;
                end
            end

            S_ISSUE: begin
                issued_d = 1'b0;
                case (op_code_q)
                    OP_IF: begin
                        if (depth_q < MAX_DEPTH) begin
                            push_c   = 1'b1;
                            ps_d_c   = op_cond_q & bus.ps_q;
                            depth_d  = depth_q + ONE;
                            issued_d = 1'b1;
                        end else begin
                            err_ovf_d = 1'b1;
                        end
                    end
                    OP_ELSE: begin
                        if (depth_q != '0) begin
                            comp_c   = 1'b1;
                            issued_d = 1'b1;
                        end else begin
                            err_unf_d = 1'b1;
                        end
                    end
                    OP_ENDIF: begin
                        if (depth_q != '0) begin
                            pop_c    = 1'b1;
                            depth_d  = depth_q - ONE;
                            issued_d = 1'b1;
                        end else begin
                            err_unf_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
                state_d = S_SETTLE;
            end

            S_SETTLE: begin
                // The pstack top now reflects the pulse issued in the previous cycle.
                if (issued_q && (op_code_q != OP_ENDIF) && bus.ps_all_false) begin
                    redir_c    = 1'b1;
                    redir_pc_d = op_target_q;
                end
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.op_ready       = (state_q == S_IDLE);
    assign bus.ps_push        = push_c;
    assign bus.ps_pop         = pop_c;
    assign bus.ps_comp        = comp_c;
    assign bus.ps_d           = ps_d_c;
    assign bus.active_mask    = bus.ps_q;
    assign bus.redirect_valid = redir_c;
    assign bus.redirect_pc    = redir_c ? op_target_q : redir_pc_q;
    assign bus.depth          = depth_q;
    assign bus.err_overflow   = err_ovf_q;
    assign bus.err_underflow  = err_unf_q;

endmodule

// File: tb/tb_simt_branch_ctrl.sv
// Directed bench for simt_branch_ctrl with a behavioural pstack whose base entry is all-ones.
`timescale 1ns/1ps
module tb_simt_branch_ctrl;

    localparam int NC = 4;
    localparam int PW = 8;
    localparam int SD = 8;
    localparam int DW = 4;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    simt_branch_ctrl_if #(.N_CORES(NC), .PC_WIDTH(PW), .DEPTH_W(DW)) bus ();

    simt_branch_ctrl #(.N_CORES(NC), .PC_WIDTH(PW), .STACK_DEPTH(SD), .DEPTH_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural pstack: entry 0 is the all-active base mask.
    logic [NC-1:0] stk [0:SD];
    int            sp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= SD; i++) stk[i] <= '0;
            stk[0] <= '1;
            sp     <= 0;
        end else if (bus.ps_push && sp < SD) begin
            stk[sp+1] <= bus.ps_d;
            sp        <= sp + 1;
        end else if (bus.ps_comp && sp > 0) begin
            stk[sp] <= ~stk[sp] & stk[sp-1];
        end else if (bus.ps_pop && sp > 0) begin
            sp <= sp - 1;
        end
    end

    assign bus.ps_q         = stk[sp];
    assign bus.ps_all_false = (stk[sp] == '0);

    typedef struct {
        logic          ready1, push1, pop1, comp1;
        logic [NC-1:0] psd1;
        logic          ready2, push2, pop2, comp2, rv2;
        logic [PW-1:0] rpc2;
        logic [NC-1:0] mask2;
        logic          ready3, rv3, ovf3, unf3;
        logic [PW-1:0] rpc3;
        logic [DW-1:0] dep3;
        logic [NC-1:0] mask3;
    } samp_t;

    localparam logic [1:0] C_IF = 2'b01, C_ELSE = 2'b10, C_ENDIF = 2'b11;

    // Offers one op for a single accept edge T and captures outputs in cycles T+1..T+3.
    task automatic send_op(input logic [1:0] code, input logic [NC-1:0] cond,
                           input logic [PW-1:0] tgt, output samp_t s);
        @(negedge clk);
        bus.op_valid  = 1'b1;
        bus.op_code   = code;
        bus.op_cond   = cond;
        bus.op_target = tgt;
        @(posedge clk);
        @(negedge clk);
        s.ready1 = bus.op_ready; s.push1 = bus.ps_push; s.pop1 = bus.ps_pop;
        s.comp1  = bus.ps_comp;  s.psd1  = bus.ps_d;
        bus.op_valid = 1'b0;
        bus.op_code  = 2'b00;
        @(negedge clk);
        s.ready2 = bus.op_ready; s.push2 = bus.ps_push; s.pop2 = bus.ps_pop;
        s.comp2  = bus.ps_comp;  s.rv2   = bus.redirect_valid;
        s.rpc2   = bus.redirect_pc; s.mask2 = bus.active_mask;
        @(negedge clk);
        s.ready3 = bus.op_ready; s.rv3 = bus.redirect_valid; s.rpc3 = bus.redirect_pc;
        s.dep3   = bus.depth; s.ovf3 = bus.err_overflow; s.unf3 = bus.err_underflow;
        s.mask3  = bus.active_mask;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.op_valid = 1'b0; bus.op_code = 2'b00; bus.op_cond = '0; bus.op_target = '0;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", bus.op_ready); end
        checks++; if ({bus.ps_push, bus.ps_pop, bus.ps_comp} !== 3'b000) begin errors++;
            $display("FAIL reset_pulses got=%b want=000", {bus.ps_push, bus.ps_pop, bus.ps_comp}); end
        checks++; if (bus.ps_d !== 4'b0000) begin errors++; $display("FAIL reset_ps_d got=%b want=0000", bus.ps_d); end
        checks++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 8'h00) begin errors++;
            $display("FAIL reset_redirect got=%b/%h want=0/00", bus.redirect_valid, bus.redirect_pc); end
        checks++; if (bus.depth !== 4'd0) begin errors++; $display("FAIL reset_depth got=%0d want=0", bus.depth); end
        checks++; if ({bus.err_overflow, bus.err_underflow} !== 2'b00) begin errors++;
            $display("FAIL reset_errors got=%b want=00", {bus.err_overflow, bus.err_underflow}); end
        checks++; if (bus.active_mask !== 4'b1111) begin errors++; $display("FAIL reset_mask got=%b want=1111", bus.active_mask); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b want=1", bus.op_ready); end
    endtask

    task automatic test_if_push();
        samp_t s;
        send_op(C_IF, 4'b1010, 8'h40, s);
        checks++; if (s.push1 !== 1'b1 || s.psd1 !== 4'b1010) begin errors++;
            $display("FAIL if_push got push=%b d=%b want 1/1010", s.push1, s.psd1); end
        checks++; if (s.push2 !== 1'b0) begin errors++; $display("FAIL if_push_width got=%b want=0", s.push2); end
        checks++; if (s.mask2 !== 4'b1010) begin errors++; $display("FAIL if_mask got=%b want=1010", s.mask2); end
        checks++; if (s.rv2 !== 1'b0) begin errors++; $display("FAIL if_no_redirect got=%b want=0", s.rv2); end
        checks++; if (s.dep3 !== 4'd1) begin errors++; $display("FAIL if_depth got=%0d want=1", s.dep3); end
        checks++; if ({s.ready1, s.ready2, s.ready3} !== 3'b001) begin errors++;
            $display("FAIL if_ready_seq got=%b want=001", {s.ready1, s.ready2, s.ready3}); end
        send_op(C_ENDIF, 4'b0000, 8'h00, s);
        checks++; if (s.pop1 !== 1'b1 || s.mask2 !== 4'b1111 || s.dep3 !== 4'd0) begin errors++;
            $display("FAIL if_unwind got pop=%b mask=%b depth=%0d want 1/1111/0", s.pop1, s.mask2, s.dep3); end
    endtask

    task automatic test_if_redirect();
        samp_t s;
        send_op(C_IF, 4'b0000, 8'h40, s);
        checks++; if (s.push1 !== 1'b1 || s.psd1 !== 4'b0000) begin errors++;
            $display("FAIL ifz_push got push=%b d=%b want 1/0000", s.push1, s.psd1); end
        checks++; if (s.rv2 !== 1'b1 || s.rpc2 !== 8'h40) begin errors++;
            $display("FAIL ifz_redirect got=%b/%h want=1/40", s.rv2, s.rpc2); end
        checks++; if (s.rv3 !== 1'b0 || s.rpc3 !== 8'h40) begin errors++;
            $display("FAIL ifz_strobe_hold got=%b/%h want=0/40", s.rv3, s.rpc3); end
        send_op(C_IF, 4'b1111, 8'h22, s);
        checks++; if (s.psd1 !== 4'b0000 || s.rv2 !== 1'b1 || s.rpc2 !== 8'h22) begin errors++;
            $display("FAIL nested_ifz got d=%b rv=%b pc=%h want 0000/1/22", s.psd1, s.rv2, s.rpc2); end
        send_op(C_ENDIF, 4'b0000, 8'h77, s);
        checks++; if (s.pop1 !== 1'b1 || s.mask2 !== 4'b0000 || s.rv2 !== 1'b0) begin errors++;
            $display("FAIL endif_no_redirect got pop=%b mask=%b rv=%b want 1/0000/0", s.pop1, s.mask2, s.rv2); end
        checks++; if (s.rpc3 !== 8'h22) begin errors++; $display("FAIL endif_pc_hold got=%h want=22", s.rpc3); end
        send_op(C_ENDIF, 4'b0000, 8'h00, s);
        checks++; if (s.mask2 !== 4'b1111 || s.dep3 !== 4'd0) begin errors++;
            $display("FAIL ifz_unwind got mask=%b depth=%0d want 1111/0", s.mask2, s.dep3); end
    endtask

    task automatic test_else();
        samp_t s;
        send_op(C_IF, 4'b1010, 8'h40, s);
        send_op(C_ELSE, 4'b0000, 8'h55, s);
        checks++; if (s.comp1 !== 1'b1 || s.push1 !== 1'b0 || s.pop1 !== 1'b0 || s.comp2 !== 1'b0) begin errors++;
            $display("FAIL else_comp got comp=%b/%b push=%b pop=%b want 1/0/0/0", s.comp1, s.comp2, s.push1, s.pop1); end
        checks++; if (s.mask2 !== 4'b0101 || s.rv2 !== 1'b0) begin errors++;
            $display("FAIL else_mask got mask=%b rv=%b want 0101/0", s.mask2, s.rv2); end
        checks++; if (s.dep3 !== 4'd1) begin errors++; $display("FAIL else_depth got=%0d want=1", s.dep3); end
        send_op(C_ENDIF, 4'b0000, 8'h00, s);
        send_op(C_IF, 4'b1111, 8'h40, s);
        checks++; if (s.mask2 !== 4'b1111 || s.rv2 !== 1'b0) begin errors++;
            $display("FAIL if_full got mask=%b rv=%b want 1111/0", s.mask2, s.rv2); end
        send_op(C_ELSE, 4'b0000, 8'h55, s);
        checks++; if (s.mask2 !== 4'b0000 || s.rv2 !== 1'b1 || s.rpc2 !== 8'h55) begin errors++;
            $display("FAIL else_redirect got mask=%b rv=%b pc=%h want 0000/1/55", s.mask2, s.rv2, s.rpc2); end
        send_op(C_ENDIF, 4'b0000, 8'h00, s);
        checks++; if (s.pop1 !== 1'b1 || s.mask2 !== 4'b1111 || s.dep3 !== 4'd0 || s.rv2 !== 1'b0) begin errors++;
            $display("FAIL else_endif got pop=%b mask=%b depth=%0d rv=%b want 1/1111/0/0", s.pop1, s.mask2, s.dep3, s.rv2); end
    endtask

    task automatic test_underflow();
        samp_t s;
        send_op(C_ENDIF, 4'b0000, 8'h00, s);
        checks++; if ({s.push1, s.pop1, s.comp1} !== 3'b000) begin errors++;
            $display("FAIL unf_endif_pulse got=%b want=000", {s.push1, s.pop1, s.comp1}); end
        checks++; if (s.unf3 !== 1'b1 || s.dep3 !== 4'd0 || s.ovf3 !== 1'b0) begin errors++;
            $display("FAIL unf_flag got unf=%b ovf=%b depth=%0d want 1/0/0", s.unf3, s.ovf3, s.dep3); end
        checks++; if (s.ready3 !== 1'b1 || s.ready2 !== 1'b0) begin errors++;
            $display("FAIL unf_ready got=%b%b want=01", s.ready2, s.ready3); end
        send_op(C_ELSE, 4'b0000, 8'h33, s);
        checks++; if (s.comp1 !== 1'b0 || s.rv2 !== 1'b0 || s.unf3 !== 1'b1) begin errors++;
            $display("FAIL unf_else got comp=%b rv=%b unf=%b want 0/0/1", s.comp1, s.rv2, s.unf3); end
    endtask

    task automatic test_overflow();
        samp_t s;
        for (int i = 0; i < 7; i++) send_op(C_IF, 4'b1111, 8'h10, s);
        checks++; if (s.dep3 !== 4'd7) begin errors++; $display("FAIL ovf_depth7 got=%0d want=7", s.dep3); end
        send_op(C_IF, 4'b0000, 8'h18, s);
        checks++; if (s.push1 !== 1'b1 || s.rv2 !== 1'b1 || s.dep3 !== 4'd8) begin errors++;
            $display("FAIL ovf_eighth got push=%b rv=%b depth=%0d want 1/1/8", s.push1, s.rv2, s.dep3); end
        send_op(C_IF, 4'b1111, 8'h19, s);
        checks++; if (s.push1 !== 1'b0 || s.rv2 !== 1'b0) begin errors++;
            $display("FAIL ovf_ninth got push=%b rv=%b want 0/0", s.push1, s.rv2); end
        checks++; if (s.ovf3 !== 1'b1 || s.dep3 !== 4'd8 || s.rpc3 !== 8'h18) begin errors++;
            $display("FAIL ovf_flag got ovf=%b depth=%0d pc=%h want 1/8/18", s.ovf3, s.dep3, s.rpc3); end
        send_op(C_ENDIF, 4'b0000, 8'h00, s);
        checks++; if (s.ovf3 !== 1'b1 || s.unf3 !== 1'b1 || s.dep3 !== 4'd7) begin errors++;
            $display("FAIL flags_sticky got ovf=%b unf=%b depth=%0d want 1/1/7", s.ovf3, s.unf3, s.dep3); end
    endtask

    task automatic test_back_to_back();
        logic p1, p2, r3, p4;
        logic [NC-1:0] d1, d4;
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = C_IF; bus.op_cond = 4'b1100; bus.op_target = 8'h10;
        @(posedge clk);
        @(negedge clk);
        p1 = bus.ps_push; d1 = bus.ps_d;
        bus.op_cond = 4'b0110; bus.op_target = 8'h20;
        @(negedge clk);
        p2 = bus.ps_push;
        @(negedge clk);
        r3 = bus.op_ready;
        @(negedge clk);
        p4 = bus.ps_push; d4 = bus.ps_d;
        bus.op_valid = 1'b0; bus.op_code = 2'b00;
        repeat (2) @(negedge clk);
        checks++; if (p1 !== 1'b1 || d1 !== 4'b1100) begin errors++;
            $display("FAIL b2b_first got push=%b d=%b want 1/1100", p1, d1); end
        checks++; if (p2 !== 1'b0 || r3 !== 1'b1) begin errors++;
            $display("FAIL b2b_busy got push@T+2=%b ready@T+3=%b want 0/1", p2, r3); end
        checks++; if (p4 !== 1'b1 || d4 !== 4'b0100) begin errors++;
            $display("FAIL b2b_second got push=%b d=%b want 1/0100", p4, d4); end
        checks++; if (bus.depth !== 4'd2 || bus.op_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_depth got depth=%0d ready=%b want 2/1", bus.depth, bus.op_ready); end
    endtask

    task automatic test_reset_mid();
        logic p_before;
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = C_IF; bus.op_cond = 4'b1111; bus.op_target = 8'h30;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op_code = 2'b00;
        p_before = bus.ps_push;
        reset = 1'b1;
        #1;
        checks++; if (p_before !== 1'b1 || bus.ps_push !== 1'b0) begin errors++;
            $display("FAIL rst_mid_pulse got before=%b after=%b want 1/0", p_before, bus.ps_push); end
        checks++; if (bus.depth !== 4'd0 || bus.op_ready !== 1'b1) begin errors++;
            $display("FAIL rst_mid_state got depth=%0d ready=%b want 0/1", bus.depth, bus.op_ready); end
        checks++; if ({bus.err_overflow, bus.err_underflow} !== 2'b00 || bus.active_mask !== 4'b1111) begin errors++;
            $display("FAIL rst_mid_clear got err=%b mask=%b want 00/1111", {bus.err_overflow, bus.err_underflow}, bus.active_mask); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_if_push();
        test_if_redirect();
        test_else();
        test_underflow();
        test_overflow();
        do_reset();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
